// File: rtl/ram_bank_fifo_ctrl_pkg.sv
// Shared defaults and sizing helpers for the ram_bank FIFO controller.
package ram_bank_pkg;

  localparam int unsigned ADDR_BIT   = 3;
  localparam int unsigned DATA_BIT   = 16;
  localparam int unsigned MEM_HEIGHT = 8;
  localparam int unsigned OBUF_DEPTH = 2;

  // The count covers bank, the in-flight read and the output buffer.
  function automatic int unsigned count_width(input int unsigned addr_bit);
    return addr_bit + 2;
  endfunction

endpackage

// File: rtl/ram_bank_fifo_ctrl_if.sv
// Push/pop streams, status and ram_bank port bundle for ram_bank_fifo_ctrl.
interface ram_bank_fifo_ctrl_if #(
  parameter int unsigned ADDR_BIT = ram_bank_pkg::ADDR_BIT,
  parameter int unsigned DATA_BIT = ram_bank_pkg::DATA_BIT
);

  logic                wr_valid;
  logic                wr_ready;
  logic [DATA_BIT-1:0] wr_data;
  logic                rd_valid;
  logic                rd_ready;
  logic [DATA_BIT-1:0] rd_data;
  logic [ADDR_BIT+1:0] count;
  logic                empty;
  logic                full;
  logic                mem_en;
  logic                mem_we;
  logic                mem_re;
  logic [ADDR_BIT-1:0] mem_addr_w;
  logic [DATA_BIT-1:0] mem_d_w;
  logic [ADDR_BIT-1:0] mem_addr_r;
  logic [DATA_BIT-1:0] mem_d_r;

  // Controller side.
  modport master (
    input  wr_valid, wr_data, rd_ready, mem_d_r,
    output wr_ready, rd_valid, rd_data, count, empty, full,
           mem_en, mem_we, mem_re, mem_addr_w, mem_d_w, mem_addr_r
  );

  // Producer/consumer/bank side.
  modport slave (
    output wr_valid, wr_data, rd_ready, mem_d_r,
    input  wr_ready, rd_valid, rd_data, count, empty, full,
           mem_en, mem_we, mem_re, mem_addr_w, mem_d_w, mem_addr_r
  );

endinterface

// File: rtl/ram_bank_fifo_ctrl_rd_skid.sv
// Two-entry output buffer that absorbs the bank's one-cycle read latency.
module ram_rd_skid #(
  parameter int unsigned DATA_BIT = ram_bank_pkg::DATA_BIT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                land_i,
  input  logic [DATA_BIT-1:0] land_data_i,
  input  logic                pop_i,
  output logic [1:0]          ocnt_o,
  output logic                valid_o,
  output logic [DATA_BIT-1:0] data_o
);

  import ram_bank_pkg::*;

  logic [OBUF_DEPTH-1:0][DATA_BIT-1:0] buf_q;
  logic [0:0] head_q, head_d;
  logic [0:0] tail;
  logic [1:0] ocnt_q, ocnt_d;
  logic       pop;

  assign pop = pop_i & (ocnt_q != 2'd0);
  // With both slots full, tail aliases head: a landing word then reuses the slot being popped.
  assign tail = head_q ^ ocnt_q[0];

  always_comb begin
    ocnt_d = ocnt_q + 2'(land_i) - 2'(pop);
    head_d = head_q ^ 1'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q  <= '0;
      head_q <= '0;
      ocnt_q <= '0;
    end else begin
      if (land_i) buf_q[tail] <= land_data_i;
      head_q <= head_d;
      ocnt_q <= ocnt_d;
    end
  end

  assign ocnt_o  = ocnt_q;
  assign valid_o = ocnt_q != 2'd0;
  assign data_o  = buf_q[head_q];

endmodule

// File: rtl/ram_bank_fifo_ctrl.sv
// Presents an external ram_bank as a circular FIFO with valid/ready push and pop streams.
module ram_bank_fifo_ctrl #(
  parameter int unsigned ADDR_BIT   = ram_bank_pkg::ADDR_BIT,
  parameter int unsigned DATA_BIT   = ram_bank_pkg::DATA_BIT,
  parameter int unsigned MEM_HEIGHT = ram_bank_pkg::MEM_HEIGHT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ram_bank_fifo_ctrl_if.master bus
);

  import ram_bank_pkg::*;

  localparam int unsigned PW = ADDR_BIT + 1;
  localparam int unsigned CW = count_width(ADDR_BIT);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] mem_cnt;
  logic          pend_q;
  logic          run_q;
  logic          push, pop, fetch;
  logic [2:0]    occ_next;
  logic [1:0]    ocnt;
  logic          obuf_valid;
  logic [CW-1:0] count;

  assign mem_cnt = wr_ptr_q - rd_ptr_q;
  assign bus.full     = mem_cnt == PW'(MEM_HEIGHT);
  assign bus.wr_ready = run_q & ~bus.full;

  assign push = bus.wr_valid & bus.wr_ready;
  assign pop  = obuf_valid & bus.rd_ready;

  // Only fetch when the buffer is guaranteed a free slot by the time the word lands.
  assign occ_next = {1'b0, ocnt} + {2'b00, pend_q} - {2'b00, pop};
  assign fetch    = (mem_cnt != '0) && (occ_next < 3'(OBUF_DEPTH));

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(fetch);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      pend_q   <= 1'b0;
      run_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      pend_q   <= fetch;
      run_q    <= 1'b1;
    end
  end

  ram_rd_skid #(
    .DATA_BIT (DATA_BIT)
  ) u_rd_skid (
    .clk         (clk),
    .rst_n       (rst_n),
    .land_i      (pend_q),
    .land_data_i (bus.mem_d_r),
    .pop_i       (pop),
    .ocnt_o      (ocnt),
    .valid_o     (obuf_valid),
    .data_o      (bus.rd_data)
  );

  assign count     = CW'(mem_cnt) + CW'(pend_q) + CW'(ocnt);
  assign bus.count = count;
  assign bus.empty = count == '0;

  assign bus.rd_valid   = obuf_valid;
  assign bus.mem_en     = run_q;
  assign bus.mem_we     = push;
  assign bus.mem_addr_w = wr_ptr_q[ADDR_BIT-1:0];
  assign bus.mem_d_w    = bus.wr_data;
  assign bus.mem_re     = fetch;
  assign bus.mem_addr_r = rd_ptr_q[ADDR_BIT-1:0];

endmodule

// File: doc/ram_bank_fifo_ctrl.md
Name: ram_bank_fifo_ctrl

Overview:
Initiator-side controller that drives a ram_bank through its write port (en/we/addr_w/d_w) and its read port (re/addr_r/d_r). It presents the bank as a circular FIFO with valid/ready push and pop streams. A 2-entry output buffer absorbs the bank's one-cycle read latency, so streaming runs at one word per cycle. It sits between a producer stream and a consumer stream, with the ram_bank instantiated alongside at the same level.

Parameters:
ADDR_BIT, 3, address width of the bank.
DATA_BIT, 16, data word width.
MEM_HEIGHT, 8, bank depth; must equal 2**ADDR_BIT.

Ports:
clk  in  1  single clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
wr_valid  in  1  producer has a word.
wr_ready  out  1  controller accepts a word this cycle.
wr_data  in  DATA_BIT  push data.
rd_valid  out  1  rd_data holds a valid word.
rd_ready  in  1  consumer takes the word this cycle.
rd_data  out  DATA_BIT  head-of-FIFO word.
count  out  ADDR_BIT+2  total words held (bank + in-flight + output buffer).
empty  out  1  count==0.
full  out  1  bank occupancy == MEM_HEIGHT.
mem_en  out  1  to ram_bank en.
mem_we  out  1  to ram_bank we.
mem_re  out  1  to ram_bank re.
mem_addr_w  out  ADDR_BIT  to ram_bank addr_w.
mem_d_w  out  DATA_BIT  to ram_bank d_w.
mem_addr_r  out  ADDR_BIT  to ram_bank addr_r.
mem_d_r  in  DATA_BIT  from ram_bank d_r.

Behaviour:
- Bank contract: write occurs at the rising edge when en&we. For a read, re/addr_r are sampled at the rising edge, and d_r is valid for the whole following cycle.
- Pointers wr_ptr and rd_ptr are ADDR_BIT+1 bits, and the extra MSB gives wrap parity. mem_cnt = wr_ptr - rd_ptr, with range 0..MEM_HEIGHT. The low ADDR_BIT bits address the bank and wrap 7->0.
- Reset (rst_n low, asynchronous):
  - wr_ptr=rd_ptr=0, pend=0, ocnt=0.
  - rd_valid=0, wr_ready=0, mem_we=0, mem_re=0, mem_en=0.
  - count=0, empty=1, full=0, rd_data=0.
  - Any in-flight read is dropped and all contents are discarded, including on a reset mid-operation.
- Out of reset:
  - mem_en=1 constantly.
  - wr_ready = !full.
- Push: when wr_valid & wr_ready in the same cycle:
  - mem_we=1, mem_addr_w=wr_ptr[ADDR_BIT-1:0], mem_d_w=wr_data.
  - wr_ptr increments at the edge.
  - When wr_valid=0, mem_we=0.
- Fetch:
  - pop = rd_valid & rd_ready.
  - Fetch is issued when mem_cnt!=0 and (ocnt + pend - pop) < 2.
  - On fetch: mem_re=1, mem_addr_r=rd_ptr[ADDR_BIT-1:0], rd_ptr increments, and pend=1 for the next cycle.
  - When no fetch is issued, mem_re=0 and pend=0 next cycle.
- Land: in a cycle with pend=1, mem_d_r is written into the output buffer tail at the edge.
- Output buffer: 2-entry FIFO, ocnt 0..2.
  - rd_valid = ocnt!=0; rd_data = buffer head.
  - Pop and land in the same cycle are both applied; ocnt is unchanged and order is preserved.
- Latency: a word pushed into an empty controller in cycle 0 gives mem_re in cycle 1 and rd_valid in cycle 3. The steady-state stream runs at 1 word per cycle in each direction.
- Capacity: MEM_HEIGHT + 2 words (10 at defaults). full reflects bank occupancy only.
- Hazard-free by construction: reads only touch occupied slots and writes only touch free slots, so no same-address read/write collision is possible.
- Simultaneous push and pop while full: pop does not free a bank slot in the same cycle, so wr_ready stays combinationally tied to the current mem_cnt only. There is no ready-from-pop combinational path.
- Pop attempts while rd_valid=0 are ignored. Pushes while wr_ready=0 are ignored, and wr_data is not written.
- rd_data and rd_valid hold stable while rd_ready=0.

Decomposition:
- Package ram_bank_pkg holds:
  - ADDR_BIT, DATA_BIT, MEM_HEIGHT defaults.
  - the constant OBUF_DEPTH=2.
  - the width function for count.
- One natural sub-module: ram_rd_skid, the 2-entry output buffer with land/pop inputs, ocnt output, and head data/valid output.
- Pointer and fetch logic stay in ram_bank_fifo_ctrl.

Test Plan:
- Idle after reset, wr_valid=0, rd_ready=0 for 10 cycles -> rd_valid=0, mem_re=0, mem_we=0, empty=1, count=0, wr_ready=1.
- Push 0..11 back-to-back with rd_ready=0 -> words 0..9 accepted, wr_ready drops after the 10th, count=10, full=1, rd_data=0 held stable.
- Then rd_ready=1 with no pushes -> rd_data sequence 0..9, one per cycle, then rd_valid=0, count=0, empty=1.
- Single push of 0xA5A5 into an empty controller at cycle 0 -> mem_re=1 with mem_addr_r=0 at cycle 1, rd_valid=1 with rd_data=0xA5A5 at cycle 3.
- Continuous push of 0..19 with rd_ready=1 -> output 0..19 in order at 1 word per cycle after the first, with mem_addr_w/mem_addr_r wrapping 7->0 twice and no drops or duplicates.
- Push 5 words, pull rd_ready=0, assert rst_n=0 mid-cycle for 2 cycles -> all outputs reach reset values immediately. After release, push 0x1234 -> it is the first word out, with none of the old data.
